// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - active-low 7-segment constants, glyph lookup and display FSM states
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    // Returns {g,f,e,d,c,b,a}, 0 = segment lit
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble core, one bit per clock
module bin2bcd_seq #(
    parameter int WIDTH = 16,
    parameter int N_NIB = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     bin,
    output logic                 busy,
    output logic                 done,
    output logic [4*N_NIB-1:0]   bcd,
    output logic                 ovf
);

    localparam int BW = 4 * N_NIB;
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] bin_q;
    logic [CW-1:0]    cnt_q;
    logic [BW-1:0]    adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < N_NIB; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // High during the final shift so the caller can step straight into its load state
    assign done = busy && (cnt_q == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            cnt_q <= '0;
            bcd   <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
        end else if (start) begin
            bin_q <= bin;
            bcd   <= '0;
            ovf   <= 1'b0;
            cnt_q <= CW'(WIDTH);
            busy  <= 1'b1;
        end else if (busy) begin
            bcd   <= {adj[BW-2:0], bin_q[WIDTH-1]};
            bin_q <= {bin_q[WIDTH-2:0], 1'b0};
            ovf   <= ovf | adj[BW-1];
            cnt_q <= cnt_q - CW'(1);
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/bin2seg_display.sv
// rtl/bin2seg_display.sv - binary to multi-digit 7-segment driver; BIN2SEG_SIGNED_EN enables two's complement input
module bin2seg_display #(
    parameter int WIDTH    = 16,
    parameter int N_DIG    = 5,
    parameter int BLANK_LZ = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [WIDTH-1:0]     i_data,
    input  logic [N_DIG-1:0]     i_dp,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic                 o_ovf,
    output logic [8*N_DIG-1:0]   o_SEG
);

    import seg7_pkg::*;

    localparam int N_NIB = N_DIG + 1;

    state_t               state;
    logic [N_DIG-1:0]     dp_q;
    logic                 start;
    logic [WIDTH-1:0]     mag;
    logic                 core_busy;
    logic                 core_done;
    logic                 core_ovf;
    logic [4*N_NIB-1:0]   bcd;
    logic [3:0]           msd;
    logic                 ovf_c;
    logic [6:0]           glyph;
    logic [8*N_DIG-1:0]   seg_c;

    assign start = (state == ST_IDLE) && o_ready && i_valid && !core_busy;

`ifdef BIN2SEG_SIGNED_EN
    logic       neg_q;
    logic [3:0] sign_pos;
    assign mag      = i_data[WIDTH-1] ? (~i_data + WIDTH'(1)) : i_data;
    assign sign_pos = (BLANK_LZ != 0) ? (msd + 4'd1) : 4'(N_DIG - 1);
`else
    assign mag = i_data;
`endif

    bin2bcd_seq #(
        .WIDTH (WIDTH),
        .N_NIB (N_NIB)
    ) u_core (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .start (start),
        .bin   (mag),
        .busy  (core_busy),
        .done  (core_done),
        .bcd   (bcd),
        .ovf   (core_ovf)
    );

    always_comb begin
        msd   = 4'd0;
        glyph = SEG_BLANK;
        seg_c = '1;
        for (int k = 0; k < N_DIG; k++) begin
            if (bcd[4*k +: 4] != 4'd0)
                msd = 4'(k);
        end
        ovf_c = core_ovf || (bcd[4*N_DIG +: 4] != 4'd0);
`ifdef BIN2SEG_SIGNED_EN
        // A negative value needs one spare digit for its dash
        if (neg_q) begin
            if (BLANK_LZ != 0) begin
                if (msd >= 4'(N_DIG - 1))
                    ovf_c = 1'b1;
            end else if (bcd[4*(N_DIG-1) +: 4] != 4'd0) begin
                ovf_c = 1'b1;
            end
        end
`endif
        for (int k = 0; k < N_DIG; k++) begin
            glyph = hex_to_seg(bcd[4*k +: 4]);
            if ((BLANK_LZ != 0) && (4'(k) > msd))
                glyph = SEG_BLANK;
`ifdef BIN2SEG_SIGNED_EN
            if (neg_q && (4'(k) == sign_pos))
                glyph = SEG_DASH;
`endif
            if (ovf_c)
                glyph = SEG_DASH;
            seg_c[8*k +: 8] = {~dp_q[k], glyph};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_ovf   <= 1'b0;
            o_SEG   <= '1;
            dp_q    <= '0;
`ifdef BIN2SEG_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            o_valid <= 1'b0;
            case (state)
                // o_ready stays low through the o_valid cycle and rises one cycle later
                ST_IDLE: begin
                    if (!o_ready) begin
                        o_ready <= 1'b1;
                    end else if (start) begin
                        o_ready <= 1'b0;
                        dp_q    <= i_dp;
`ifdef BIN2SEG_SIGNED_EN
                        neg_q   <= i_data[WIDTH-1];
`endif
                        state   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (core_done)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    o_SEG   <= seg_c;
                    o_ovf   <= ovf_c;
                    o_valid <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2seg_display.sv
// tb/tb_bin2seg_display.sv - directed self-checking bench for bin2seg_display
module tb_bin2seg_display;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic [15:0] d0 = '0, d1 = '0, d2 = '0;
    logic [4:0]  dp0 = '0, dp1 = '0;
    logic [3:0]  dp2 = '0;
    logic        r0, r1, r2, ov0, ov1, ov2, of0, of1, of2;
    logic [39:0] s0, s1;
    logic [31:0] s2;

    int n_cmp = 0;
    int n_bad = 0;

    bin2seg_display #(.WIDTH(16), .N_DIG(5), .BLANK_LZ(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v0), .i_data(d0), .i_dp(dp0),
        .o_ready(r0), .o_valid(ov0), .o_ovf(of0), .o_SEG(s0));

    bin2seg_display #(.WIDTH(16), .N_DIG(5), .BLANK_LZ(0)) dut_nb (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .i_data(d1), .i_dp(dp1),
        .o_ready(r1), .o_valid(ov1), .o_ovf(of1), .o_SEG(s1));

    bin2seg_display #(.WIDTH(16), .N_DIG(4), .BLANK_LZ(1)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v2), .i_data(d2), .i_dp(dp2),
        .o_ready(r2), .o_valid(ov2), .o_ovf(of2), .o_SEG(s2));

    task automatic drive(input int sel, input logic val, input logic [15:0] d, input logic [4:0] dp);
        case (sel)
            0: begin v0 = val; d0 = d; dp0 = dp; end
            1: begin v1 = val; d1 = d; dp1 = dp; end
            default: begin v2 = val; d2 = d; dp2 = dp[3:0]; end
        endcase
    endtask

    task automatic sample(input int sel, output logic rdy, output logic vld, output logic ovf,
                          output logic [39:0] seg);
        case (sel)
            0: begin rdy = r0; vld = ov0; ovf = of0; seg = s0; end
            1: begin rdy = r1; vld = ov1; ovf = of1; seg = s1; end
            default: begin rdy = r2; vld = ov2; ovf = of2; seg = {8'h00, s2}; end
        endcase
    endtask

    // Issue one value and wait (bounded) for o_valid; lat counts cycles after the accept edge
    task automatic run(input int sel, input logic [15:0] d, input logic [4:0] dp,
                       output logic [39:0] seg, output logic ovf, output int lat);
        logic rdy, vld, of;
        logic [39:0] sg;
        lat = -1;
        seg = '0;
        ovf = 1'b0;
        @(negedge clk);
        drive(sel, 1'b1, d, dp);
        @(negedge clk);
        drive(sel, 1'b0, d, dp);
        for (int k = 1; k <= 40; k++) begin
            sample(sel, rdy, vld, of, sg);
            if (vld) begin
                lat = k;
                seg = sg;
                ovf = of;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        n_cmp++; if (s0 !== 40'hFF_FFFF_FFFF) begin n_bad++; $display("FAIL reset_seg got %h want %h", s0, 40'hFF_FFFF_FFFF); end
        n_cmp++; if (r0 !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", r0); end
        n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", ov0); end
        n_cmp++; if (of0 !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", of0); end
        n_cmp++; if (s2 !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_seg4 got %h want ffffffff", s2); end
    endtask

    task automatic test_basic;
        logic [39:0] seg; logic ovf; int lat;
        run(0, 16'd12345, 5'b0, seg, ovf, lat);
        n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL basic_latency got %0d want 18", lat); end
        n_cmp++; if (seg !== 40'hF9A4B09992) begin n_bad++; $display("FAIL basic_12345 got %h want f9a4b09992", seg); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL basic_ovf got %b want 0", ovf); end
    endtask

    task automatic test_handshake;
        int low_bad = 0;
        logic rdy_end;
        @(negedge clk);
        drive(0, 1'b1, 16'd5, 5'b0);
        @(negedge clk);
        drive(0, 1'b0, 16'd5, 5'b0);
        for (int k = 1; k <= 18; k++) begin
            if (r0 !== 1'b0) low_bad++;
            @(negedge clk);
        end
        rdy_end = r0;
        n_cmp++; if (low_bad != 0) begin n_bad++; $display("FAIL ready_low_window got %0d high cycles want 0", low_bad); end
        n_cmp++; if (rdy_end !== 1'b1) begin n_bad++; $display("FAIL ready_return got %b want 1", rdy_end); end
        n_cmp++; if (s0 !== 40'hFFFFFFFF92) begin n_bad++; $display("FAIL handshake_5 got %h want ffffffff92", s0); end
    endtask

    task automatic test_blanking;
        logic [39:0] seg; logic ovf; int lat;
        run(0, 16'd7, 5'b0, seg, ovf, lat);
        n_cmp++; if (seg !== 40'hFFFFFFFFF8) begin n_bad++; $display("FAIL blank_7 got %h want fffffffff8", seg); end
        run(0, 16'd0, 5'b0, seg, ovf, lat);
        n_cmp++; if (seg !== 40'hFFFFFFFFC0) begin n_bad++; $display("FAIL blank_0 got %h want ffffffffc0", seg); end
        run(0, 16'd100, 5'b0, seg, ovf, lat);
        n_cmp++; if (seg !== 40'hFFFFF9C0C0) begin n_bad++; $display("FAIL blank_100 got %h want fffff9c0c0", seg); end
        run(0, 16'd10000, 5'b0, seg, ovf, lat);
        n_cmp++; if (seg !== 40'hF9C0C0C0C0) begin n_bad++; $display("FAIL blank_10000 got %h want f9c0c0c0c0", seg); end
        run(1, 16'd7, 5'b0, seg, ovf, lat);
        n_cmp++; if (seg !== 40'hC0C0C0C0F8) begin n_bad++; $display("FAIL noblank_7 got %h want c0c0c0c0f8", seg); end
        run(1, 16'd0, 5'b0, seg, ovf, lat);
        n_cmp++; if (seg !== 40'hC0C0C0C0C0) begin n_bad++; $display("FAIL noblank_0 got %h want c0c0c0c0c0", seg); end
    endtask

    task automatic test_overflow;
        logic [39:0] seg; logic ovf; int lat;
        run(2, 16'd65535, 5'b0, seg, ovf, lat);
        n_cmp++; if (seg !== 40'h00BFBFBFBF) begin n_bad++; $display("FAIL ovf_65535 got %h want bfbfbfbf", seg); end
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag_65535 got %b want 1", ovf); end
        run(2, 16'd9999, 5'b0, seg, ovf, lat);
        n_cmp++; if (seg !== 40'h0090909090) begin n_bad++; $display("FAIL ovf_9999 got %h want 90909090", seg); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_flag_9999 got %b want 0", ovf); end
        run(2, 16'd10000, 5'b0, seg, ovf, lat);
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag_10000 got %b want 1", ovf); end
        run(2, 16'd1234, 5'b00100, seg, ovf, lat);
        n_cmp++; if (seg !== 40'h00F924B099) begin n_bad++; $display("FAIL dp_1234 got %h want f924b099", seg); end
        run(2, 16'd65535, 5'b00001, seg, ovf, lat);
        n_cmp++; if (seg !== 40'h00BFBFBF3F) begin n_bad++; $display("FAIL ovf_dp got %h want bfbfbf3f", seg); end
    endtask

    task automatic test_sign;
        logic [39:0] seg; logic ovf; int lat;
`ifdef BIN2SEG_SIGNED_EN
        run(0, 16'hFFD6, 5'b0, seg, ovf, lat);
        n_cmp++; if (seg !== 40'hFFFFBF99A4) begin n_bad++; $display("FAIL neg42 got %h want ffffbf99a4", seg); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL neg42_ovf got %b want 0", ovf); end
        run(0, 16'hD8F1, 5'b0, seg, ovf, lat);
        n_cmp++; if (seg !== 40'hBF90909090) begin n_bad++; $display("FAIL neg9999 got %h want bf90909090", seg); end
        run(1, 16'hFFD6, 5'b0, seg, ovf, lat);
        n_cmp++; if (seg !== 40'hBFC0C099A4) begin n_bad++; $display("FAIL neg42_noblank got %h want bfc0c099a4", seg); end
        run(0, 16'h8000, 5'b0, seg, ovf, lat);
        n_cmp++; if (seg !== 40'hBFBFBFBFBF) begin n_bad++; $display("FAIL neg32768 got %h want bfbfbfbfbf", seg); end
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL neg32768_ovf got %b want 1", ovf); end
`else
        run(0, 16'hFFD6, 5'b0, seg, ovf, lat);
        n_cmp++; if (seg !== 40'h8292999099) begin n_bad++; $display("FAIL u65494 got %h want 8292999099", seg); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL u65494_ovf got %b want 0", ovf); end
        run(0, 16'h8000, 5'b0, seg, ovf, lat);
        n_cmp++; if (seg !== 40'hB0A4F88280) begin n_bad++; $display("FAIL u32768 got %h want b0a4f88280", seg); end
`endif
    endtask

    task automatic test_ignore_busy;
        int cnt = 0;
        logic rdy, vld, of;
        logic [39:0] sg;
        logic [39:0] last = '0;
        @(negedge clk);
        drive(0, 1'b1, 16'd321, 5'b0);
        @(negedge clk);
        drive(0, 1'b0, 16'd321, 5'b0);
        for (int k = 1; k <= 45; k++) begin
            if (k == 5) drive(0, 1'b1, 16'd999, 5'b0);
            if (k == 6) drive(0, 1'b0, 16'd999, 5'b0);
            sample(0, rdy, vld, of, sg);
            if (vld) begin cnt++; last = sg; end
            @(negedge clk);
        end
        n_cmp++; if (cnt != 1) begin n_bad++; $display("FAIL busy_single_valid got %0d want 1", cnt); end
        n_cmp++; if (last !== 40'hFFFFB0A4F9) begin n_bad++; $display("FAIL busy_value got %h want ffffb0a4f9", last); end
        n_cmp++; if (s0 !== 40'hFFFFB0A4F9) begin n_bad++; $display("FAIL seg_hold got %h want ffffb0a4f9", s0); end
    endtask

    task automatic test_reset_mid;
        logic [39:0] seg; logic ovf; int lat;
        @(negedge clk);
        drive(0, 1'b1, 16'd555, 5'b11111);
        @(negedge clk);
        drive(0, 1'b0, 16'd555, 5'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (s0 !== 40'hFF_FFFF_FFFF) begin n_bad++; $display("FAIL midrst_seg got %h want ffffffffff", s0); end
        n_cmp++; if (r0 !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", r0); end
        n_cmp++; if (of2 !== 1'b0) begin n_bad++; $display("FAIL midrst_ovf got %b want 0", of2); end
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++; if (s0 !== 40'hFF_FFFF_FFFF) begin n_bad++; $display("FAIL midrst_aborted got %h want ffffffffff", s0); end
        run(0, 16'd42, 5'b0, seg, ovf, lat);
        n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL midrst_recover_lat got %0d want 18", lat); end
        n_cmp++; if (seg !== 40'hFFFFFF99A4) begin n_bad++; $display("FAIL midrst_recover got %h want ffffff99a4", seg); end
    endtask

    task automatic test_back_to_back;
        logic [39:0] seg; logic ovf; int lat;
        run(0, 16'd1, 5'b0, seg, ovf, lat);
        n_cmp++; if (seg !== 40'hFFFFFFFFF9) begin n_bad++; $display("FAIL b2b_first got %h want fffffffff9", seg); end
        run(0, 16'd2, 5'b10000, seg, ovf, lat);
        n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL b2b_lat got %0d want 18", lat); end
        n_cmp++; if (seg !== 40'h7FFFFFFFA4) begin n_bad++; $display("FAIL b2b_second got %h want 7fffffffa4", seg); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_basic;
        test_handshake;
        test_blanking;
        test_overflow;
        test_sign;
        test_ignore_busy;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
